// File: rtl/reg_bank_pkg.sv
// Shared definitions for the addressed register bank.
//   op_e        : per-cell operation code (hold / increment / load / clear)
//   clog2_min1  : ceil(log2(n)), never less than 1, for address widths
package reg_bank_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_INC  = 2'd1,
    OP_LOAD = 2'd2,
    OP_CLR  = 2'd3
  } op_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/reg_cell_w.sv
// One register of the bank plus its sticky overflow flag.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   op         : decoded operation for this cycle (already prioritised)
//   load_data  : value taken on OP_LOAD
//   q          : registered value
//   ovf        : sticky overflow flag, set when an increment carries out
module reg_cell_w
  import reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter              RESET_VAL = 0,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  op_e              op,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] val_q, val_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    val_d = val_q;
    ovf_d = ovf_q;
    // Increment in WIDTH+1 bits; the carry-out is the overflow condition.
    sum   = {1'b0, val_q} + {{WIDTH{1'b0}}, 1'b1};
    case (op)
      OP_CLR: begin
        val_d = '0;
        ovf_d = 1'b0;
      end
      OP_LOAD: begin
        val_d = load_data;
        ovf_d = 1'b0;
      end
      OP_INC: begin
        if (sum[WIDTH]) begin
          val_d = SATURATE ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
          ovf_d = 1'b1;
        end else begin
          val_d = sum[WIDTH-1:0];
        end
      end
      default: begin
        val_d = val_q;
        ovf_d = ovf_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= RST_V;
      ovf_q <= 1'b0;
    end else begin
      val_q <= val_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = val_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/reg_bank_w.sv
// Bank of DEPTH write-enabled registers for the pointcloud datapath.
// Each register supports bus load, clear and increment (wrap or saturate)
// with a sticky per-register overflow flag.
// Ports:
//   Clk, Rst  : clock, asynchronous active-high reset
//   BusOut    : write data; WEN/WADDR select the single bus-written register
//   INC, CLR  : per-register increment / synchronous clear requests
//   RADDR     : read select for dout (0 when out of range)
//   dout      : combinational read of register RADDR (no write bypass)
//   dout_all  : all registers, register i at [i*WIDTH +: WIDTH]
//   ovf       : sticky per-register overflow flags
module reg_bank_w
  import reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = clog2_min1(DEPTH),
  parameter              RESET_VAL = 0,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [WIDTH-1:0]       BusOut,
  input  logic                   WEN,
  input  logic [ADDR_W-1:0]      WADDR,
  input  logic [DEPTH-1:0]       INC,
  input  logic [DEPTH-1:0]       CLR,
  input  logic [ADDR_W-1:0]      RADDR,
  output logic [WIDTH-1:0]       dout,
  output logic [DEPTH*WIDTH-1:0] dout_all,
  output logic [DEPTH-1:0]       ovf
);

  op_e              cell_op [DEPTH];
  logic [WIDTH-1:0] cell_q  [DEPTH];

  // Fixed priority per register: clear, then bus write, then increment.
  // A WADDR beyond DEPTH-1 matches no register, so the write is dropped.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cell_op[i] = OP_HOLD;
      if (CLR[i]) begin
        cell_op[i] = OP_CLR;
      end else if (WEN && (WADDR == ADDR_W'(i))) begin
        cell_op[i] = OP_LOAD;
      end else if (INC[i]) begin
        cell_op[i] = OP_INC;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    reg_cell_w #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL),
      .SATURATE (SATURATE)
    ) u_cell (
      .clk      (Clk),
      .rst      (Rst),
      .op       (cell_op[g]),
      .load_data(BusOut),
      .q        (cell_q[g]),
      .ovf      (ovf[g])
    );
    assign dout_all[g*WIDTH +: WIDTH] = cell_q[g];
  end

  // Compare-based mux so an out-of-range RADDR falls through to zero.
  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (RADDR == ADDR_W'(i)) begin
        dout = cell_q[i];
      end
    end
  end

endmodule
